// File: rtl/bounce_gen_if.sv
// Command handshake for bounce_gen: a clean target level offered with valid/ready.
interface bounce_gen_if;
  logic cmd_valid;
  logic cmd_level;
  logic cmd_ready;

  modport master (output cmd_valid, output cmd_level, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_level, output cmd_ready);
endinterface

// File: rtl/bounce_gen.sv
// Mechanical-contact emulator: drives a bouncy raw button that settles at the commanded level.
// Define BOUNCE_GEN_RANDOM_EN to stretch each toggle gap by an LFSR-derived random amount.
module bounce_gen #(
  parameter int          NUM_BOUNCES   = 3,
  parameter int          MIN_GAP       = 1000,
  parameter int          GAP_BITS      = 12,
  parameter int          SETTLE_CYCLES = 500_000,
  parameter logic        INIT_LEVEL    = 1'b0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  bounce_gen_if.slave  cmd,
  output logic         button_raw,
  output logic         busy,
  output logic         done
);

  localparam int TW = (NUM_BOUNCES == 0) ? 1 : $clog2(2*NUM_BOUNCES + 1);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  state_t        state;
  logic [31:0]   gap_cnt;
  logic [31:0]   settle_cnt;
  logic [TW-1:0] toggles_left;
  logic          target;
  logic [31:0]   gap;

`ifdef BOUNCE_GEN_RANDOM_EN
  logic [15:0] lfsr;

  // Galois form of x^16+x^14+x^13+x^11+1; free-running so gap sequence depends only on the seed
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign gap = 32'(MIN_GAP) + 32'(lfsr[GAP_BITS-1:0]);
`else
  assign gap = 32'(MIN_GAP);
`endif

  assign cmd.cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      button_raw   <= INIT_LEVEL;
      busy         <= 1'b0;
      done         <= 1'b0;
      gap_cnt      <= '0;
      settle_cnt   <= '0;
      toggles_left <= '0;
      target       <= INIT_LEVEL;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            target <= cmd.cmd_level;
            if (cmd.cmd_level == button_raw) begin
              done <= 1'b1;
            end else begin
              // first edge lands on the accept edge itself
              button_raw   <= ~button_raw;
              toggles_left <= TW'(2*NUM_BOUNCES);
              gap_cnt      <= gap;
              busy         <= 1'b1;
              if (NUM_BOUNCES == 0) begin
                settle_cnt <= 32'(SETTLE_CYCLES);
                state      <= SETTLE;
              end else begin
                state      <= BOUNCE;
              end
            end
          end
        end
        BOUNCE: begin
          if (gap_cnt == 32'd1) begin
            gap_cnt      <= gap;
            toggles_left <= toggles_left - 1'b1;
            if (toggles_left == TW'(1)) begin
              // even toggle count, so this edge lands on the captured target
              button_raw <= target;
              settle_cnt <= 32'(SETTLE_CYCLES);
              state      <= SETTLE;
            end else begin
              button_raw <= ~button_raw;
            end
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 32'd1;
          if (settle_cnt == 32'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bounce_gen.md
Name: bounce_gen

Overview:
- Synthesizable mechanical-contact emulator; the source end of the raw-button interface that the debouncer consumes.
- Takes a clean level command through a valid/ready handshake.
- Drives a single-bit raw output that bounces a configurable number of times before settling at the commanded level.
- Used on-board and in benches to drive debounce logic without a physical switch.

Parameters:
- NUM_BOUNCES, 3, extra toggle pairs after the first edge; 0 gives a single clean edge.
- MIN_GAP, 1000, minimum clocks between successive toggles; must be >= 1.
- GAP_BITS, 12, width of the random gap extension; used only with the optional feature.
- SETTLE_CYCLES, 500_000, clocks the final level is held before `done`; must be >= 1.
- INIT_LEVEL, 1'b0, `button_raw` value after reset.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_level  input  1  target settled level
- cmd_ready  output  1  generator accepts a command this cycle
- button_raw  output  1  emulated bouncy contact, registered
- busy  output  1  bounce or settle in progress
- done  output  1  one-clock pulse when the output has settled

Behaviour:
- Single clock `clk`. Reset is synchronous and active-high on `rst`.
- Reset values: `button_raw`=INIT_LEVEL, state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, LFSR=LFSR_SEED, counters 0.
- Reset mid-operation aborts immediately. On the next edge `button_raw` returns to INIT_LEVEL; no `done` is issued.
- Handshake: a command is accepted on a clock edge where `cmd_valid` && `cmd_ready`.
  - `cmd_ready` = 1 only in IDLE (combinational from state).
  - A source holding `cmd_valid` while busy is simply stalled; nothing is queued or dropped.
- FSM states: IDLE, BOUNCE, SETTLE.
- IDLE, accepted command with `cmd_level` == `button_raw`:
  - Stay in IDLE; `button_raw` does not change.
  - `done`=1 for the single following cycle.
- IDLE, accepted command with `cmd_level` != `button_raw`:
  - Toggle `button_raw` on that same edge, so it equals `cmd_level` in cycle T+1.
  - Load toggles_left = 2*NUM_BOUNCES and load the gap counter with gap.
  - Go to BOUNCE, or straight to SETTLE if NUM_BOUNCES = 0.
- BOUNCE:
  - The gap counter decrements every cycle.
  - On the cycle it would reach 0: toggle `button_raw`, decrement toggles_left, reload gap.
  - Successive toggles are therefore exactly gap clocks apart.
  - When toggles_left reaches 0, `button_raw` equals `cmd_level` (even toggle count). Load the settle counter with SETTLE_CYCLES and go to SETTLE.
- SETTLE:
  - `button_raw` is held; the counter decrements.
  - On expiry go to IDLE. `done`=1 and `cmd_ready`=1 in that first IDLE cycle.
  - The first final edge occurs at cycle E; `done` fires at E+SETTLE_CYCLES.
- `busy` = 1 in BOUNCE and SETTLE, 0 otherwise.
- `cmd_level` is captured at acceptance. Later changes on `cmd_level` are ignored until the next accept.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle regardless of state; freezes only during reset.
- Counter widths:
  - Gap counter: 32 bits.
  - Settle counter: 32 bits.
  - toggles_left: clog2(2*NUM_BOUNCES+1) bits, minimum 1.
  - No counter wraps; all are reloaded before reuse.

Optional Feature:
- Macro: BOUNCE_GEN_RANDOM_EN.
- Defined: gap = MIN_GAP + lfsr[GAP_BITS-1:0], sampled at each reload. Gap range is MIN_GAP .. MIN_GAP+2^GAP_BITS-1. Toggle spacing is irregular but reproducible from LFSR_SEED.
- Undefined: gap = MIN_GAP always, giving fully deterministic timing. The LFSR and GAP_BITS logic are omitted.
- The test plan below assumes the macro is undefined.

Test Plan:
- Config for all scenarios: NUM_BOUNCES=2, MIN_GAP=4, SETTLE_CYCLES=10, INIT_LEVEL=0.
- Reset: hold `rst`=1 for 2 cycles -> `button_raw`=0, `cmd_ready`=1, `busy`=0, `done`=0.
- Rising command: accept `cmd_level`=1 at edge T -> `button_raw`=1 at T+1, 0 at T+5, 1 at T+9, 0 at T+13, 1 at T+17 -> `done` and `cmd_ready` both 1 at T+27; `busy`=1 over T+1..T+26.
- Same-level command: with `button_raw`=1, accept `cmd_level`=1 -> `button_raw` never changes, `busy` stays 0, `done`=1 exactly at T+1.
- Back-pressure: hold `cmd_valid`=1 with `cmd_level`=0 from T+3 during a busy rising command -> not accepted until T+27; first toggle to 0 at T+28.
- Reset mid-bounce: assert `rst` at T+6 of a rising command -> `button_raw`=0, IDLE, `cmd_ready`=1 on the next edge, and no `done` pulse ever appears.
- Loopback: connect `button_raw` to the debouncer with WAIT_COUNT=6, then issue a rising command -> exactly one debouncer `pulse`, occurring 6 clocks after the T+17 edge.
